// File: rtl/axi_dmem_slave_pkg.sv
// Shared definitions for the AXI4-Lite data-memory slave.
//   dmem_state_e : FSM state encoding (also exported on debug_state)
//   RESP_*       : AXI response codes returned on rresp/bresp
package axi_dmem_slave_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_RESP = 3'd3
  } dmem_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_dmem_slave_dmem_bram.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x 32 bits, per-byte write enable,
// one-cycle registered read. No reset on the array or the output register so
// the tools map it onto block RAM.
//   clk   : clock
//   addr  : word address
//   re    : read enable, rdata valid the cycle after
//   we    : byte write enables, bit i writes wdata[8i+7:8i]
//   wdata : write data
//   rdata : registered read data
module dmem_bram
  import axi_dmem_slave_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  re,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_dmem_slave.sv
// AXI4-Lite slave terminating the core data-memory bus onto an on-chip
// byte-writable RAM. One transaction in flight at a time.
//
//   state   | meaning
//   --------+------------------------------------------
//   IDLE    | accepting a new read or write request
//   RD_WAIT | RAM read in progress
//   RD_RESP | rvalid held until rready
//   WR_RESP | bvalid held until bready
//
// Ports: clk/rstn (async active-low), AXI4-Lite AR/R/AW/W/B channels
// (arprot/awprot ignored), debug_state = current FSM state.
module axi_dmem_slave
  import axi_dmem_slave_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [2:0]  debug_state
);

  dmem_state_e           state;
  logic                  rd_in_range;
  logic                  wr_req, wr_go, ar_go;
  logic                  aw_in_range, ar_in_range;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;

  // Sub-word address bits and protection attributes carry no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, axi_arprot, axi_awprot, axi_araddr[1:0], axi_awaddr[1:0]};

  assign aw_in_range = (axi_awaddr[31:DEPTH_LOG2+2] == '0);
  assign ar_in_range = (axi_araddr[31:DEPTH_LOG2+2] == '0);

  // AW and W are only taken together; a complete write beats a pending read.
  assign wr_req = axi_awvalid && axi_wvalid;
  assign wr_go  = (state == IDLE) && wr_req;
  assign ar_go  = (state == IDLE) && axi_arvalid && !wr_req;

  assign axi_awready = wr_go;
  assign axi_wready  = wr_go;
  assign axi_arready = (state == IDLE) && !wr_req;

  // Single RAM port shared by both channels; they never fire together.
  assign ram_addr = wr_go ? axi_awaddr[DEPTH_LOG2+1:2] : axi_araddr[DEPTH_LOG2+1:2];
  assign ram_we   = (wr_go && aw_in_range) ? axi_wstrb : 4'b0000;

  dmem_bram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bram (
    .clk   (clk),
    .addr  (ram_addr),
    .re    (ar_go),
    .we    (ram_we),
    .wdata (axi_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rd_in_range <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
      axi_rvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      axi_bvalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_go) begin
            axi_bvalid <= 1'b1;
            axi_bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            state      <= WR_RESP;
          end else if (ar_go) begin
            rd_in_range <= ar_in_range;
            state       <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Out-of-range reads alias a real word in the RAM; mask it off.
          axi_rdata  <= rd_in_range ? ram_rdata : 32'h0;
          axi_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
          axi_rvalid <= 1'b1;
          state      <= RD_RESP;
        end
        RD_RESP: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        WR_RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_axi_dmem_slave.sv
module tb_axi_dmem_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [2:0]  axi_arprot = '0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b1;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [2:0]  axi_awprot = '0;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b1;
  logic [2:0]  debug_state;

  int n_vec = 0;
  int n_err = 0;

  logic [33:0] rq[$];  // {rresp, rdata}
  logic [1:0]  bq[$];

  always #5 clk = ~clk;

  axi_dmem_slave #(.DEPTH_LOG2(14)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .axi_araddr  (axi_araddr),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_arprot  (axi_arprot),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_awaddr  (axi_awaddr),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_awprot  (axi_awprot),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .debug_state (debug_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares whenever a response handshake is presented.
  always @(negedge clk) begin
    if (rstn) begin
      if (axi_rvalid && axi_rready) begin
        if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          logic [33:0] e;
          e = rq.pop_front();
          check("rdata", axi_rdata, e[31:0]);
          check("rresp", {30'd0, axi_rresp}, {30'd0, e[33:32]});
        end
      end
      if (axi_bvalid && axi_bready) begin
        if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else begin
          logic [1:0] eb;
          eb = bq.pop_front();
          check("bresp", {30'd0, axi_bresp}, {30'd0, eb});
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    bit ok;
    int lat;
    bq.push_back(exp_resp);
    @(posedge clk); #1;
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_awready && axi_wready) begin ok = 1; break; end
    end
    check("aw_handshake_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    ok = 0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); lat++;
      if (axi_bvalid) begin ok = 1; break; end
    end
    check("wr_latency", lat, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("idle_after_b", {29'd0, debug_state}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input int stall);
    bit ok;
    int lat;
    rq.push_back({exp_r, exp_d});
    @(posedge clk); #1;
    axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = (stall == 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_arready) begin ok = 1; break; end
    end
    check("ar_handshake_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    ok = 0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); lat++;
      if (axi_rvalid) begin ok = 1; break; end
    end
    check("rd_latency", lat, 32'd2);
    for (int s = 0; s < stall; s++) begin
      check("stall_rvalid", {31'd0, axi_rvalid}, 32'd1);
      check("stall_rdata", axi_rdata, exp_d);
      check("stall_arready", {31'd0, axi_arready}, 32'd0);
      @(negedge clk);
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      axi_rready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("idle_after_r", {29'd0, debug_state}, 32'd0);
    check("rvalid_low_after_r", {31'd0, axi_rvalid}, 32'd0);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {29'd0, debug_state}, 32'd0);
    check("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    check("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    check("rst_resps", {28'd0, axi_rresp, axi_bresp}, 32'd0);
    check("rst_arready", {31'd0, axi_arready}, 32'd1);
    check("rst_aw_w_ready", {30'd0, axi_awready, axi_wready}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Lone AW or lone W must not be accepted.
    axi_awvalid = 1'b1;
    @(negedge clk);
    check("lone_aw_ready", {30'd0, axi_awready, axi_wready}, 32'd0);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b1;
    @(negedge clk);
    check("lone_w_ready", {30'd0, axi_awready, axi_wready}, 32'd0);
    check("lone_w_state", {29'd0, debug_state}, 32'd0);
    @(posedge clk); #1;
    axi_wvalid = 1'b0;

    do_write(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, OKAY);
    do_read (32'h0000_0100, 32'hDEAD_BEEF, OKAY, 0);
    do_write(32'h0000_0100, 32'h0000_00AA, 4'b0001, OKAY);
    do_read (32'h0000_0103, 32'hDEAD_BEAA, OKAY, 0);
    do_write(32'h0000_0100, 32'h1122_3344, 4'b1100, OKAY);
    do_read (32'h0000_0100, 32'h1122_BEAA, OKAY, 0);

    // Write and read requested in the same cycle: write wins.
    bq.push_back(OKAY);
    rq.push_back({OKAY, 32'h1234_5678});
    @(posedge clk); #1;
    axi_awaddr = 32'h200; axi_wdata = 32'h1234_5678; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_araddr = 32'h200; axi_arvalid = 1'b1;
    @(negedge clk);
    check("sim_arready", {31'd0, axi_arready}, 32'd0);
    check("sim_awready", {31'd0, axi_awready}, 32'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(negedge clk);
    check("sim_wr_resp_state", {29'd0, debug_state}, 32'd3);
    check("sim_arready_busy", {31'd0, axi_arready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("sim_arready_idle", {31'd0, axi_arready}, 32'd1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_rvalid) begin ok = 1; break; end
    end
    check("sim_rvalid_seen", {31'd0, ok}, 32'd1);
    @(posedge clk);

    // Out-of-range address aliases word 0 in the index bits.
    do_write(32'h0000_0000, 32'hCAFE_F00D, 4'b1111, OKAY);
    do_write(32'h0001_0000, 32'hFFFF_FFFF, 4'b1111, SLVERR);
    do_read (32'h0001_0000, 32'h0000_0000, SLVERR, 0);
    do_read (32'h0000_0000, 32'hCAFE_F00D, OKAY, 0);
    do_read (32'h8000_0200, 32'h0000_0000, SLVERR, 0);

    // Backpressure on R.
    do_read (32'h0000_0200, 32'h1234_5678, OKAY, 5);

    // Reset in the middle of RD_RESP.
    @(posedge clk); #1;
    axi_araddr = 32'h100; axi_arvalid = 1'b1; axi_rready = 1'b0;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_rvalid) begin ok = 1; break; end
    end
    check("rst_mid_rvalid_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("rst_mid_rvalid", {31'd0, axi_rvalid}, 32'd0);
    check("rst_mid_state", {29'd0, debug_state}, 32'd0);
    check("rst_mid_rdata", axi_rdata, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; axi_rready = 1'b1;

    // RAM survives reset.
    do_read (32'h0000_0100, 32'h1122_BEAA, OKAY, 0);

    repeat (2) @(posedge clk);
    check("rq_drained", rq.size(), 32'd0);
    check("bq_drained", bq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_dmem_slave.md
# axi_dmem_slave

AXI4-Lite slave that terminates the core's data-memory bus and backs it with an on-chip, byte-writable block RAM. It sits directly downstream of the core's MMU master port and accepts one transaction at a time. Each transaction runs through a small handshake state machine. It returns OKAY for in-range accesses and SLVERR for out-of-range ones.

## Interface
- DEPTH_LOG2, 14, log2 of RAM depth in 32-bit words (16384 words = 64 KiB)
- clk  in  1  single clock, all logic rising-edge
- rstn  in  1  asynchronous active-low reset
- axi_araddr  in  32  read address
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_arprot  in  3  ignored
- axi_rdata  out  32  read data
- axi_rresp  out  2  read response
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready
- axi_awaddr  in  32  write address
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_awprot  in  3  ignored
- axi_wdata  in  32  write data
- axi_wstrb  in  4  byte enables, bit i selects wdata[8i+7:8i]
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_bresp  out  2  write response
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response ready
- debug_state  out  3  current FSM state encoding

## Operation
- FSM states:
  - IDLE=0: accepts new requests.
  - RD_WAIT=1: RAM read in progress.
  - RD_RESP=2: rvalid held until rready.
  - WR_RESP=3: bvalid held until bready.
- Address decode:
  - Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored.
  - In range iff addr[31:DEPTH_LOG2+2]==0.
- Write path (IDLE):
  - awready=wready=1 only when awvalid&&wvalid; AW and W are always accepted in the same cycle.
  - A lone awvalid or lone wvalid is not accepted.
  - On handshake, RAM is written with the wstrb byte mask if in range; out of range writes nothing.
  - Next state WR_RESP; bresp=00 (in range) or 10 (out of range).
- Read path (IDLE):
  - arready = !(awvalid&&wvalid), i.e. a complete write request takes priority over a read in the same cycle.
  - On AR handshake: latch the range flag, issue the RAM read, go to RD_WAIT.
- RD_WAIT → RD_RESP unconditionally. Capture rdata = RAM output (or 0 if out of range) and rresp = 00/10.
- RD_RESP: rvalid=1; rdata/rresp stable until rready; then go to IDLE.
- WR_RESP: bvalid=1; bresp stable until bready; then go to IDLE.
- All ready signals are 0 outside IDLE.
- Reset:
  - All outputs 0, state IDLE.
  - Reset mid-transaction abandons it; a write already committed at a handshake edge stays in RAM.
  - RAM contents are not cleared by reset.

## Timing
- Write: handshake at edge 0 writes RAM at that edge; bvalid=1 from cycle 1. Minimum 2 cycles per write (bready tied high).
- Read: handshake at edge 0, RAM read at edge 1, rvalid=1 from cycle 2. Minimum 3 cycles per read.
- Back-to-back: the next request is accepted earliest in the cycle after the response handshake. No overlap.
- Read-after-write to the same word returns the new data; guaranteed because write completes before any read is accepted.
- Ready signals are combinational from state and valids. All other outputs are registered.

## Structure
- Shared package holds:
  - State encoding constants IDLE/RD_WAIT/RD_RESP/WR_RESP.
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- One sub-module, dmem_bram: single-port synchronous RAM, 2^DEPTH_LOG2 x 32, 4-bit byte write enable, 1-cycle read latency, no output reset; must infer block RAM.

## Test plan
- Reset with all valids low → all outputs 0, debug_state=0, arready=1, awready=wready=0.
- Write 0xDEADBEEF to 0x100 with wstrb=1111, bready=1 → bvalid in cycle 1 with bresp=00. Read 0x100 → rvalid in cycle 2, rdata=0xDEADBEEF, rresp=00.
- Write 0x000000AA to 0x100 with wstrb=0001, then read 0x100 → rdata=0xDEADBEAA.
- Simultaneous awvalid/wvalid/arvalid to 0x200 (write 0x12345678) → write accepted first, arready=0 that cycle. Following read returns 0x12345678.
- Write/read at 0x00010000 (out of range for DEPTH_LOG2=14) → bresp=10, rresp=10, rdata=0; word 0 unchanged.
- Hold rready=0 for 5 cycles → rvalid and rdata stable, arready=0. Assert rready → IDLE next cycle. Deassert rstn during RD_RESP → rvalid drops immediately.
